fetch_sequencer: RTL and testbench

- Front end of the core. Holds the program counter and fetches one IW-bit instruction at a time from instruction memory over a req/ack handshake.
- Presents each fetched instruction to the execute stage (ALU) over a valid/ready handshake.
- Non-branch instructions: advances the PC by 1.
- Branch instructions: waits for the ALU's resolved PC offset (the immediate if taken, 1 if not taken) and adds that offset to the PC.

---
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, fetches one instruction over
// req/ack and hands it to execute over valid/ready, following branches.
module fetch_sequencer #(
    parameter int AW       = 8,
    parameter int IW       = 8,
    parameter int DW       = 8,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic          ex_valid,
    output logic [IW-1:0] ex_instr,
    input  logic          ex_ready,
    input  logic          ex_res_valid,
    input  logic [DW-1:0] ex_res,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic [15:0]   retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        RESOLVE,
        HALTED
    } state_t;

    localparam logic [AW-1:0] PC0 = AW'(RESET_PC);

    state_t        state;
    logic [IW-1:0] instr_reg;
    logic [AW-1:0] offset;

    // ALU offset zero-extended or truncated to the PC width
    assign offset = AW'(ex_res);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= PC0;
            instr_reg <= '0;
            retired   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= PC0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ex_ready) begin
                        if (instr_reg[0]) begin
                            state <= RESOLVE;
                        end else begin
                            pc      <= pc + AW'(1);
                            retired <= retired + 16'd1;
                            state   <= FETCH;
                        end
                    end
                end
                RESOLVE: begin
                    if (ex_res_valid) begin
                        retired <= retired + 16'd1;
                        // a zero offset is a branch to itself: stop here
                        if (offset == '0) begin
                            state <= HALTED;
                        end else begin
                            pc    <= pc + offset;
                            state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    if (start) begin
                        pc      <= PC0;
                        retired <= '0;
                        state   <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign ex_valid  = (state == ISSUE);
    assign ex_instr  = instr_reg;
    assign busy      = (state == FETCH) || (state == ISSUE) ||
                       (state == RESOLVE);
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an issue scoreboard.
// Expected (instr, pc) pairs are queued up front and popped on each accept.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic        ex_valid;
    logic [7:0]  ex_instr;
    logic        ex_ready;
    logic        ex_res_valid;
    logic [7:0]  ex_res;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;

    fetch_sequencer #(.AW(8), .IW(8), .DW(8), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ex_valid     (ex_valid),
        .ex_instr     (ex_instr),
        .ex_ready     (ex_ready),
        .ex_res_valid (ex_res_valid),
        .ex_res       (ex_res),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .retired      (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_rdata = mem[imem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] ins, input logic [7:0] p);
        exp_q.push_back({ins, p});
    endtask

    // Scoreboard: each accepted instruction must match the next queued one
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            logic [15:0] e;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty: observed instr %0h expected none",
                       ex_instr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (ex_instr === e[15:8]) else begin
                    errors++;
                    $error("FAIL sb_instr: observed %0h expected %0h",
                           ex_instr, e[15:8]);
                end
                checks++;
                assert (pc === e[7:0]) else begin
                    errors++;
                    $error("FAIL sb_pc: observed %0h expected %0h",
                           pc, e[7:0]);
                end
            end
        end
    end

    // Branch: issue, then return the offset one cycle after acceptance
    task automatic run_b(input logic [7:0] ins, input logic [7:0] p,
                         input logic [7:0] off);
        push(ins, p);
        tick();
        tick();
        chk("resolve_valid", ex_valid, 1'b0);
        chk("resolve_busy", busy, 1'b1);
        ex_res_valid = 1'b1;
        ex_res = off;
        tick();
        ex_res_valid = 1'b0;
        ex_res = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]    = 8'h00;
        mem[1]    = 8'h04;
        mem[2]    = 8'h08;
        mem[3]    = 8'h15;
        mem[4]    = 8'h22;
        mem[5]    = 8'h30;
        mem[6]    = 8'h07;
        mem[8]    = 8'h01;
        mem[8'hFE] = 8'h03;

        rst_n = 1'b0;
        start = 1'b0;
        imem_ack = 1'b1;
        ex_ready = 1'b1;
        ex_res_valid = 1'b0;
        ex_res = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_instr", ex_instr, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_retired", retired, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 1'b0);

        // straight-line code
        push(8'h00, 8'h00);
        push(8'h04, 8'h01);
        push(8'h08, 8'h02);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("issue_valid", ex_valid, 1'b1);
            tick();
            chk("line_pc", pc, i);
        end
        chk("line_retired", retired, 16'd3);

        // taken branch 3 -> 8
        run_b(8'h15, 8'h03, 8'h05);
        chk("taken_pc", pc, 8'h08);
        chk("taken_addr", imem_addr, 8'h08);
        chk("taken_req", imem_req, 1'b1);
        chk("taken_retired", retired, 16'd4);

        // 8 -> FE, then wrap FE -> 03, then not-taken 03 -> 04
        run_b(8'h01, 8'h08, 8'hF6);
        chk("to_fe_pc", pc, 8'hFE);
        run_b(8'h03, 8'hFE, 8'h05);
        chk("wrap_pc", pc, 8'h03);
        run_b(8'h15, 8'h03, 8'h01);
        chk("nt_pc", pc, 8'h04);
        chk("nt_retired", retired, 16'd7);

        // backpressure on pc 4
        push(8'h22, 8'h04);
        ex_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", ex_valid, 1'b1);
            chk("bp_instr", ex_instr, 8'h22);
            chk("bp_pc", pc, 8'h04);
            tick();
        end
        ex_ready = 1'b1;
        chk("bp_valid5", ex_valid, 1'b1);
        tick();
        chk("bp_pc_after", pc, 8'h05);
        chk("bp_retired", retired, 16'd8);

        // memory wait states on pc 5, spurious ex_res_valid in FETCH
        push(8'h30, 8'h05);
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("ws_req", imem_req, 1'b1);
            chk("ws_addr", imem_addr, 8'h05);
            if (k == 1) begin
                ex_res_valid = 1'b1;
                ex_res = 8'h09;
            end
            tick();
            ex_res_valid = 1'b0;
            ex_res = 8'h00;
        end
        imem_ack = 1'b1;
        chk("ws_req4", imem_req, 1'b1);
        chk("ws_addr4", imem_addr, 8'h05);
        tick();
        chk("ws_issue", ex_valid, 1'b1);
        chk("ws_pc", pc, 8'h05);
        tick();
        chk("ws_pc_after", pc, 8'h06);

        // self-loop halts
        run_b(8'h07, 8'h06, 8'h00);
        chk("halt_halted", halted, 1'b1);
        chk("halt_busy", busy, 1'b0);
        chk("halt_pc", pc, 8'h06);
        chk("halt_retired", retired, 16'd10);
        tick();
        chk("halt_stay", halted, 1'b1);
        chk("halt_req", imem_req, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_pc", pc, 8'h00);
        chk("restart_retired", retired, 16'd0);
        chk("restart_busy", busy, 1'b1);
        chk("restart_halted", halted, 1'b0);

        // rerun to the branch at pc 3, reset during RESOLVE
        push(8'h00, 8'h00);
        push(8'h04, 8'h01);
        push(8'h08, 8'h02);
        push(8'h15, 8'h03);
        repeat (6) tick();
        chk("rerun_pc", pc, 8'h03);
        tick();
        tick();
        chk("pre_rst_valid", ex_valid, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_valid", ex_valid, 1'b0);
        chk("mid_rst_instr", ex_instr, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_halted", halted, 1'b0);
        chk("mid_rst_pc", pc, 8'h00);
        chk("mid_rst_retired", retired, 16'd0);
        tick();
        rst_n = 1'b1;
        ex_res_valid = 1'b1;
        ex_res = 8'h05;
        tick();
        ex_res_valid = 1'b0;
        tick();
        chk("post_rst_pc", pc, 8'h00);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_retired", retired, 16'd0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
